// File: rtl/fetch_pkg.sv
// fetch_pkg: shared slot type and constants for the fetch queue (fault field present only with FETCH_MISALIGN_CHECK_EN)
package fetch_pkg;
   localparam int DEPTH_DEF = 4;
   localparam int XLEN_DEF = 32;
   localparam logic [XLEN_DEF-1:0] NOP_INSTR = 32'h00000013;
   typedef struct packed {
      logic [XLEN_DEF-1:0] pc;
      logic [XLEN_DEF-1:0] instr;
`ifdef FETCH_MISALIGN_CHECK_EN
      logic fault;
`endif
      logic filled;
   } fetch_slot_t;
endpackage

// File: rtl/fetch_slots.sv
// fetch_slots: slot RAM with alloc/fill/head pointers and occupancy; FETCH_MISALIGN_CHECK_EN lets fill skip fault slots
module fetch_slots
   import fetch_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF,
   parameter int XLEN = XLEN_DEF
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    flush,
   input  logic                    push,
   input  logic [XLEN-1:0]         push_pc,
`ifdef FETCH_MISALIGN_CHECK_EN
   input  logic                    push_fault,
`endif
   input  logic                    fill,
   input  logic [XLEN-1:0]         fill_data,
   input  logic                    pop,
   output logic                    full,
   output logic                    empty,
   output logic [$clog2(DEPTH):0]  pend,
   output fetch_slot_t             head
);
   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   fetch_slot_t slots [DEPTH];
   logic [PW-1:0] alloc_ptr, fill_ptr, head_ptr, used, fill_at;
   assign used = alloc_ptr - head_ptr;
   assign full = used == PW'(DEPTH);
   assign empty = used == '0;
   assign head = slots[head_ptr[AW-1:0]];
`ifdef FETCH_MISALIGN_CHECK_EN
   logic [PW-1:0] idx;
   // oldest unfilled slot from fill_ptr onward, and how many memory requests are still outstanding
   always_comb begin
      fill_at = alloc_ptr;
      pend = '0;
      idx = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         idx = fill_ptr + PW'(i);
         if (PW'(i) < alloc_ptr - fill_ptr && !slots[idx[AW-1:0]].filled) begin
            fill_at = idx;
            pend = pend + PW'(1);
         end
      end
   end
`else
   assign fill_at = fill_ptr;
   assign pend = alloc_ptr - fill_ptr;
`endif
   // slot writes and pointer moves; flush rewinds every pointer and invalidates all slots
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         alloc_ptr <= '0;
         fill_ptr <= '0;
         head_ptr <= '0;
         for (int i = 0; i < DEPTH; i++) slots[i] <= '0;
      end else if (flush) begin
         alloc_ptr <= '0;
         fill_ptr <= '0;
         head_ptr <= '0;
         for (int i = 0; i < DEPTH; i++) slots[i].filled <= 1'b0;
      end else begin
         if (push) begin
            slots[alloc_ptr[AW-1:0]].pc <= push_pc;
`ifdef FETCH_MISALIGN_CHECK_EN
            slots[alloc_ptr[AW-1:0]].fault <= push_fault;
            slots[alloc_ptr[AW-1:0]].filled <= push_fault;
            if (push_fault) slots[alloc_ptr[AW-1:0]].instr <= NOP_INSTR;
`else
            slots[alloc_ptr[AW-1:0]].filled <= 1'b0;
`endif
            alloc_ptr <= alloc_ptr + PW'(1);
         end
         if (fill) begin
            slots[fill_at[AW-1:0]].instr <= fill_data;
            slots[fill_at[AW-1:0]].filled <= 1'b1;
            fill_ptr <= fill_at + PW'(1);
         end else begin
            fill_ptr <= fill_at;
         end
         if (pop) head_ptr <= head_ptr + PW'(1);
      end
   end
endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: fetch stage pairing PCs with in-order memory responses for decode; FETCH_MISALIGN_CHECK_EN adds misaligned-PC faults
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF,
   parameter int XLEN = XLEN_DEF
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            pc_valid,
   input  logic [XLEN-1:0] pc_in,
   output logic            pc_ready,
   input  logic            flush,
   output logic            imem_req_valid,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_req_ready,
   input  logic            imem_rsp_valid,
   input  logic [XLEN-1:0] imem_rsp_data,
   output logic            dec_valid,
   output logic [XLEN-1:0] dec_pc,
   output logic [XLEN-1:0] dec_instr,
   output logic            dec_fault,
   input  logic            dec_ready
);
   localparam int PW = $clog2(DEPTH) + 1;
   localparam int DW = PW + 4;
   logic full, empty, open, mis, fill, pop;
   logic [PW-1:0] pend;
   logic [DW-1:0] drop_cnt, drop_next;
   fetch_slot_t head;
   assign open = reset & pc_valid & !full & !flush;
`ifdef FETCH_MISALIGN_CHECK_EN
   assign mis = pc_in[1:0] != 2'b00;
   assign pc_ready = open & (mis | imem_req_ready);
   assign dec_fault = dec_valid & head.fault;
`else
   assign mis = 1'b0;
   assign pc_ready = open & imem_req_ready;
   assign dec_fault = 1'b0;
`endif
   assign imem_req_valid = open & !mis;
   assign imem_addr = pc_in;
   assign dec_valid = !flush & !empty & head.filled;
   assign dec_pc = head.pc;
   assign dec_instr = head.instr;
   assign pop = dec_valid & dec_ready;
   assign fill = imem_rsp_valid & (drop_cnt == '0) & !flush;
   // responses still owed by memory for flushed requests, less any response landing this cycle
   always_comb begin
      drop_next = drop_cnt;
      if (imem_rsp_valid & (drop_cnt != '0)) drop_next = drop_cnt - DW'(1);
      if (flush) drop_next = drop_next + DW'(pend) - DW'(imem_rsp_valid & (drop_cnt == '0));
   end
   // discard counter register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) drop_cnt <= '0;
      else drop_cnt <= drop_next;
   end
   fetch_slots #(.DEPTH(DEPTH), .XLEN(XLEN)) u_slots (
      .clk(clk),
      .reset(reset),
      .flush(flush),
      .push(pc_ready),
      .push_pc(pc_in),
`ifdef FETCH_MISALIGN_CHECK_EN
      .push_fault(mis),
`endif
      .fill(fill),
      .fill_data(imem_rsp_data),
      .pop(pop),
      .full(full),
      .empty(empty),
      .pend(pend),
      .head(head)
   );
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed checks of issue, pairing, back-pressure, flush/drop and wrap for fetch_queue
module tb_fetch_queue;
   logic clk, reset, pc_valid, pc_ready, flush, imem_req_valid, imem_req_ready, imem_rsp_valid;
   logic dec_valid, dec_fault, dec_ready;
   logic [31:0] pc_in, imem_addr, imem_rsp_data, dec_pc, dec_instr;
   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
      logic f;
   } exp_t;
   exp_t exq[$];
   logic [31:0] mq[$];
   logic [31:0] pcs[$];
   int rc[$];
   int total = 0, bad = 0, cyc = 0, n_rdy = 0;
   logic mem_on = 1'b1, lat_on = 1'b0;

   fetch_queue dut (
      .clk(clk), .reset(reset), .pc_valid(pc_valid), .pc_in(pc_in), .pc_ready(pc_ready),
      .flush(flush), .imem_req_valid(imem_req_valid), .imem_addr(imem_addr),
      .imem_req_ready(imem_req_ready), .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
      .dec_valid(dec_valid), .dec_pc(dec_pc), .dec_instr(dec_instr), .dec_fault(dec_fault),
      .dec_ready(dec_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] model(input logic [31:0] a);
      return 32'hA + (a >> 2);
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", tag, got, exp);
      end
   endtask

   task automatic load();
      pc_valid = pcs.size() > 0;
      pc_in = pc_valid ? pcs[0] : 32'h0;
   endtask

   task automatic step();
      logic acc;
      exp_t e;
      #1;
      acc = pc_ready;
      if (pc_ready) n_rdy++;
      if (imem_req_valid && imem_req_ready) mq.push_back(imem_addr);
      if (dec_valid && dec_ready) begin
         if (exq.size() > 0) e = exq.pop_front();
         else e = '{32'hdeadbeef, 32'hdeadbeef, 1'b1};
         chk("dec_pc", dec_pc, e.pc);
         chk("dec_instr", dec_instr, e.instr);
         chk("dec_fault", 32'(dec_fault), 32'(e.f));
         if (lat_on) chk("dec_lat", 32'(cyc - rc.pop_front()), 32'd1);
      end
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (acc) void'(pcs.pop_front());
      load();
      imem_rsp_valid = mem_on && mq.size() > 0;
      imem_rsp_data = imem_rsp_valid ? model(mq.pop_front()) : 32'h0;
      if (imem_rsp_valid && lat_on) rc.push_back(cyc);
   endtask

   initial begin
      reset = 1'b0;
      flush = 1'b0;
      dec_ready = 1'b0;
      imem_req_ready = 1'b1;
      imem_rsp_valid = 1'b0;
      imem_rsp_data = 32'h0;
      pcs.push_back(32'h0);
      load();
      repeat (3) begin
         @(negedge clk);
         #1;
         chk("rst_req_v", 32'(imem_req_valid), 32'd0);
         chk("rst_pc_ready", 32'(pc_ready), 32'd0);
         chk("rst_dec_v", 32'(dec_valid), 32'd0);
      end
      chk("rst_dec_pc", dec_pc, 32'h0);
      chk("rst_dec_instr", dec_instr, 32'h0);
      chk("rst_dec_fault", 32'(dec_fault), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("first_req_v", 32'(imem_req_valid), 32'd1);
      chk("first_addr", imem_addr, 32'h0);

      pcs.push_back(32'h4);
      pcs.push_back(32'h8);
      exq.push_back('{32'h0, 32'hA, 1'b0});
      exq.push_back('{32'h4, 32'hB, 1'b0});
      exq.push_back('{32'h8, 32'hC, 1'b0});
      dec_ready = 1'b1;
      lat_on = 1'b1;
      repeat (8) step();
      lat_on = 1'b0;
      chk("stream_done", 32'(exq.size()), 32'd0);

      dec_ready = 1'b0;
      n_rdy = 0;
      for (int i = 0; i < 8; i++) pcs.push_back(32'h100 + 32'(4 * i));
      exq.push_back('{32'h100, 32'h4A, 1'b0});
      load();
      repeat (10) step();
      chk("full_issues", 32'(n_rdy), 32'd4);
      dec_ready = 1'b1;
      step();
      dec_ready = 1'b0;
      repeat (6) step();
      chk("one_more_issue", 32'(n_rdy), 32'd5);
      chk("bp_pop_done", 32'(exq.size()), 32'd0);
      pcs.delete();
      load();
      flush = 1'b1;
      #1;
      chk("flush_mask_dec", 32'(dec_valid), 32'd0);
      chk("flush_no_req", 32'(imem_req_valid), 32'd0);
      step();
      flush = 1'b0;
      #1;
      chk("post_flush_dec", 32'(dec_valid), 32'd0);

      mem_on = 1'b0;
      dec_ready = 1'b1;
      pcs.push_back(32'h10);
      pcs.push_back(32'h14);
      load();
      repeat (2) step();
      chk("inflight_two", 32'(mq.size()), 32'd2);
      flush = 1'b1;
      step();
      flush = 1'b0;
      mem_on = 1'b1;
      pcs.push_back(32'h40);
      exq.push_back('{32'h40, 32'h1A, 1'b0});
      load();
      repeat (8) step();
      chk("drop_two_done", 32'(exq.size()), 32'd0);

      mem_on = 1'b0;
      pcs.push_back(32'h20);
      pcs.push_back(32'h24);
      load();
      step();
      mem_on = 1'b1;
      step();
      chk("rsp_at_flush", 32'(imem_rsp_valid), 32'd1);
      flush = 1'b1;
      step();
      flush = 1'b0;
      pcs.push_back(32'h44);
      exq.push_back('{32'h44, 32'h1B, 1'b0});
      load();
      repeat (8) step();
      chk("drop_one_done", 32'(exq.size()), 32'd0);

`ifdef FETCH_MISALIGN_CHECK_EN
      pcs.push_back(32'h6);
      pcs.push_back(32'h8);
      exq.push_back('{32'h6, 32'h00000013, 1'b1});
      exq.push_back('{32'h8, 32'hC, 1'b0});
      load();
      #1;
      chk("mis_no_req", 32'(imem_req_valid), 32'd0);
      chk("mis_pc_ready", 32'(pc_ready), 32'd1);
      repeat (6) step();
      chk("mis_done", 32'(exq.size()), 32'd0);
`else
      pcs.push_back(32'h6);
      exq.push_back('{32'h6, 32'hB, 1'b0});
      load();
      #1;
      chk("mis_req_v", 32'(imem_req_valid), 32'd1);
      chk("mis_addr", imem_addr, 32'h6);
      repeat (5) step();
      chk("mis_done", 32'(exq.size()), 32'd0);
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction-fetch stage directly downstream of the program-counter stage.
- Accepts fetch addresses from the PC stage over a valid/ready handshake and issues in-order requests to instruction memory.
- Pairs each returning instruction word with its PC in a small slot queue and delivers {pc, instr} to decode over valid/ready.
- Provides back-pressure to the PC stage; supports flush on redirect (jump/branch), including discard of in-flight responses.

Parameters:
- DEPTH, 4, number of queue slots (power of two, 2..16); bounds queued plus in-flight fetches.
- XLEN, 32, address and instruction width.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous active-low reset (0 = reset).
- pc_valid  input  1  PC stage presents a fetch address.
- pc_in  input  XLEN  fetch address.
- pc_ready  output  1  address accepted this cycle.
- flush  input  1  redirect; discard all queued and in-flight fetches.
- imem_req_valid  output  1  memory request valid.
- imem_addr  output  XLEN  memory request address.
- imem_req_ready  input  1  memory accepts request.
- imem_rsp_valid  input  1  memory returns a word (in order, latency ≥1 cycle).
- imem_rsp_data  input  XLEN  returned instruction word.
- dec_valid  output  1  entry available to decode.
- dec_pc  output  XLEN  PC of head entry.
- dec_instr  output  XLEN  instruction of head entry.
- dec_fault  output  1  head entry is misaligned (optional feature; otherwise 0).
- dec_ready  input  1  decode consumes head entry.

Behaviour:
- Slot array of DEPTH entries {pc, instr, fault, filled}, with three pointers of $clog2(DEPTH)+1 bits (extra wrap bit):
  - alloc_ptr: advanced on issue.
  - fill_ptr: advanced on response.
  - head_ptr: advanced on pop.
- used = alloc_ptr - head_ptr. Full when used == DEPTH; empty when used == 0.
- Issue (combinational):
  - imem_req_valid = pc_valid & !full & !flush; imem_addr = pc_in.
  - pc_ready = imem_req_valid & imem_req_ready.
- On pc_ready: slot[alloc].pc <= pc_in, filled <= 0, alloc_ptr++.
- Response:
  - If drop_cnt > 0: response discarded and drop_cnt--.
  - Else: slot[fill].instr <= imem_rsp_data, filled <= 1, fill_ptr++.
- Output:
  - dec_valid = !empty & slot[head].filled; dec_pc/dec_instr come from slot[head].
  - Registered path only; no response-to-decode bypass. A response at cycle N gives dec_valid at N+1 at the earliest.
- Pop on dec_valid & dec_ready: head_ptr++. Push and pop in the same cycle when full is legal: pop frees a slot next cycle; issue is still blocked this cycle because full is evaluated pre-pop.
- Flush (synchronous, highest priority):
  - All three pointers go to 0 and all filled bits clear.
  - drop_cnt <= (alloc_ptr - fill_ptr) - (imem_rsp_valid & drop_cnt==0 ? 1 : 0) + (drop_cnt - (imem_rsp_valid & drop_cnt>0 ? 1 : 0)). This counts every in-flight request, minus any response arriving that cycle (which is itself discarded).
  - No issue and no pop in the flush cycle; dec_valid is masked to 0 during flush.
- New requests may issue while drop_cnt > 0. Responses are in order, so the dropped ones return first.
- Reset: all pointers 0, drop_cnt 0, filled bits 0. Hence dec_valid=0, imem_req_valid=0, pc_ready=0, dec_pc=0, dec_instr=0, dec_fault=0. Asserting reset mid-operation abandons all state immediately. The memory must also be reset by the same reset.
- Wrap-around: pointers wrap modulo 2·DEPTH; slot index = ptr[$clog2(DEPTH)-1:0].

Optional Feature:
- Macro: FETCH_MISALIGN_CHECK_EN.
- Defined:
  - pc_in[1:0] != 0 allocates a slot with fault=1, filled=1 and issues no memory request (imem_req_valid=0; pc_ready = !full & !flush).
  - dec_instr for that entry = 32'h00000013 (NOP); dec_fault=1.
  - Such slots are skipped by fill_ptr: fill_ptr advances past filled-fault slots so it always points at the oldest outstanding request.
- Undefined: address low bits are passed through unchanged, dec_fault is tied 0, and no fault storage is synthesized.

Decomposition:
- Package fetch_pkg:
  - typedef fetch_slot_t {pc, instr, fault, filled}.
  - localparam NOP_INSTR = 32'h00000013.
  - Default DEPTH constant.
- Sub-module fetch_slots: the slot RAM plus the three pointers and the full/empty logic. The top level holds the handshakes, drop_cnt and flush.

Test Plan:
- Reset low for 3 cycles, then release with pc_valid=1 -> all outputs 0 during reset; first request imem_addr=0x0 in the cycle after release.
- Stream pc 0x0,0x4,0x8 with 1-cycle memory returning 0xA,0xB,0xC and dec_ready=1 -> dec pairs (0x0,0xA),(0x4,0xB),(0x8,0xC) in order, each one cycle after its response.
- DEPTH=4, dec_ready=0, continuous pc_valid -> exactly 4 pc_ready pulses, then pc_ready=0. One dec_ready pulse -> exactly one further issue.
- Two requests in flight (0x10,0x14), flush, then request 0x40 -> the responses for 0x10 and 0x14 are dropped; the first dec_pc is 0x40 with its own data.
- Flush in the same cycle as a response, with one more request outstanding -> drop_cnt=1 and both old responses are discarded.
- With FETCH_MISALIGN_CHECK_EN: pc_in=0x6 -> no memory request; dec_valid with dec_pc=0x6, dec_instr=0x00000013, dec_fault=1.
